// File: rtl/rv_pipe_pkg.sv
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared opcode, list and sizing constants for the pipe control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv_pipe_pkg;

  localparam int REG_W = 3;
  localparam int NREGS = 8;
  localparam int OPC_W = 4;

  localparam logic [3:0] OPC_LM = 4'b1100;
  localparam logic [3:0] OPC_SM = 4'b1101;
  localparam logic [3:0] OPC_LA = 4'b1110;
  localparam logic [3:0] OPC_SA = 4'b1111;

  // LA/SA move R0..R6 only; R7 is the PC.
  localparam logic [7:0] LA_SA_LIST = 8'h7F;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/prio_enc8.sv
// ============================================================================
// Module      : prio_enc8
// Description : Lowest-set-bit encoder over 8 bits with any/single-bit flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       any,
  output logic       onehot_last
);

  // Descending scan so the lowest set bit is written last and wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign any         = |vec;
  assign onehot_last = any & ((vec & (vec - 8'd1)) == 8'd0);

endmodule

`default_nettype wire

// File: rtl/lmsm_sequencer.sv
// ============================================================================
// Module      : lmsm_sequencer
// Description : Expands LM/SM/LA/SA into one single-register micro-op per cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lmsm_sequencer #(
  parameter int REG_W = rv_pipe_pkg::REG_W,
  parameter int NREGS = rv_pipe_pkg::NREGS,
  parameter int OPC_W = rv_pipe_pkg::OPC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic [REG_W-1:0] instr_ra,
  input  logic [NREGS-1:0] instr_list,
  output logic             instr_ready,
  input  logic             stall_in,
  input  logic             flush,
  output logic             uop_valid,
  output logic             uop_is_load,
  output logic [REG_W-1:0] uop_k,
  output logic [REG_W-1:0] uop_base,
  output logic [REG_W-1:0] uop_offset,
  output logic             uop_last,
  output logic             freeze_fetch,
  output logic             busy
);

  import rv_pipe_pkg::*;

  logic [0:0]       state_q,  state_d;
  logic [NREGS-1:0] list_q,   list_d;
  logic [REG_W-1:0] offset_q, offset_d;
  logic [REG_W-1:0] base_q,   base_d;
  logic             load_q,   load_d;

  logic             w_is_lasa;
  logic             w_is_multi;
  logic [NREGS-1:0] w_eff_list;
  logic             w_start;
  logic             w_accept;
  logic [REG_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;

  assign w_is_lasa  = (instr_opcode == OPC_LA) || (instr_opcode == OPC_SA);
  assign w_is_multi = w_is_lasa || (instr_opcode == OPC_LM) || (instr_opcode == OPC_SM);
  assign w_eff_list = w_is_lasa ? LA_SA_LIST : instr_list;
  // An empty effective list is consumed as a NOP, so it never starts a sequence.
  assign w_start    = instr_valid & w_is_multi & (w_eff_list != '0) & ~flush;
  assign w_accept   = (state_q == ST_IDLE) & w_start & ~stall_in;

  prio_enc8 u_enc (
    .vec         (list_q),
    .idx         (w_idx),
    .any         (w_any),
    .onehot_last (w_single)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      list_q   <= '0;
      offset_q <= '0;
      base_q   <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      offset_q <= offset_d;
      base_q   <= base_d;
      load_q   <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    offset_d = offset_q;
    base_d   = base_q;
    load_d   = load_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d  = ST_SEQ;
          list_d   = w_eff_list;
          offset_d = '0;
          base_d   = instr_ra;
          load_d   = (instr_opcode == OPC_LM) || (instr_opcode == OPC_LA);
        end
      end
      default: begin
        if (flush) begin
          state_d  = ST_IDLE;
          list_d   = '0;
          offset_d = '0;
        end else if (!stall_in) begin
          list_d = list_q & ~(NREGS'(1) << w_idx);
          if (w_single) begin
            state_d  = ST_IDLE;
            offset_d = '0;
          end else begin
            offset_d = offset_q + REG_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    instr_ready  = (state_q == ST_IDLE) & ~stall_in;
    busy         = (state_q == ST_SEQ);
    uop_valid    = busy & w_any;
    uop_k        = w_idx;
    uop_last     = busy & w_single;
    uop_offset   = offset_q;
    uop_base     = base_q;
    uop_is_load  = load_q;
    freeze_fetch = busy | ((state_q == ST_IDLE) & w_start);
  end

endmodule

`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
// ============================================================================
// Module      : tb_lmsm_sequencer
// Description : Vector table, corner sequences and randomized model checks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lmsm_sequencer;

  import rv_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] instr_opcode = 4'd0;
  logic [2:0] instr_ra = 3'd0;
  logic [7:0] instr_list = 8'd0;
  logic       stall_in = 1'b0;
  logic       flush = 1'b0;

  logic       instr_ready;
  logic       uop_valid;
  logic       uop_is_load;
  logic [2:0] uop_k;
  logic [2:0] uop_base;
  logic [2:0] uop_offset;
  logic       uop_last;
  logic       freeze_fetch;
  logic       busy;

  int errors = 0;
  int checks = 0;

  lmsm_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_ra     (instr_ra),
    .instr_list   (instr_list),
    .instr_ready  (instr_ready),
    .stall_in     (stall_in),
    .flush        (flush),
    .uop_valid    (uop_valid),
    .uop_is_load  (uop_is_load),
    .uop_k        (uop_k),
    .uop_base     (uop_base),
    .uop_offset   (uop_offset),
    .uop_last     (uop_last),
    .freeze_fetch (freeze_fetch),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] opc;
    logic [2:0] ra;
    logic [7:0] list;
    int         n;
    logic [7:0] kmask;
    logic       load;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input logic v, input logic [3:0] o, input logic [2:0] r, input logic [7:0] l);
    instr_valid  = v;
    instr_opcode = o;
    instr_ra     = r;
    instr_list   = l;
  endtask

  task automatic exp_uop(input string nm, input logic v, input int k, input int off, input logic last);
    chk({nm, ".valid"}, uop_valid, v);
    if (v) begin
      chk({nm, ".k"}, uop_k, k);
      chk({nm, ".offset"}, uop_offset, off);
      chk({nm, ".last"}, uop_last, last);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int kcur;
    string nm;
    kcur = 0;
    nm = $sformatf("vec%0d", id);
    @(negedge clk);
    put(1'b1, v.opc, v.ra, v.list);
    #1;
    chk({nm, ".ready"}, instr_ready, 1);
    chk({nm, ".freeze_acc"}, freeze_fetch, v.n != 0);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      #1;
      while (kcur < 8 && !v.kmask[kcur]) kcur++;
      exp_uop($sformatf("%s.u%0d", nm, i), 1'b1, kcur, i, i == v.n - 1);
      chk({nm, ".load"}, uop_is_load, v.load);
      chk({nm, ".base"}, uop_base, v.ra);
      chk({nm, ".freeze"}, freeze_fetch, 1);
      kcur++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk({nm, ".end_valid"}, uop_valid, 0);
    chk({nm, ".end_busy"}, busy, 0);
  endtask

  // Reference model: pending transfers as a queue of register numbers.
  bit         m_act;
  int         m_q[$];
  int         m_off;
  logic [2:0] m_base;
  logic       m_load;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{OPC_LM, 3'd3, 8'hA5, 4, 8'hA5, 1'b1};
    tbl[1] = '{OPC_SA, 3'd5, 8'hFF, 7, 8'h7F, 1'b0};
    tbl[2] = '{OPC_SM, 3'd1, 8'h12, 2, 8'h12, 1'b0};
    tbl[3] = '{OPC_LM, 3'd2, 8'h00, 0, 8'h00, 1'b1};
    tbl[4] = '{OPC_LA, 3'd6, 8'h00, 7, 8'h7F, 1'b1};
    tbl[5] = '{OPC_SM, 3'd7, 8'h80, 1, 8'h80, 1'b0};
    tbl[6] = '{OPC_LM, 3'd0, 8'hFF, 8, 8'hFF, 1'b1};
    tbl[7] = '{4'b0011, 3'd4, 8'hFF, 0, 8'h00, 1'b0};

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    exp_uop("reset", 1'b0, 0, 0, 1'b0);
    chk("reset.k", uop_k, 0);
    chk("reset.offset", uop_offset, 0);
    chk("reset.last", uop_last, 0);
    chk("reset.busy", busy, 0);
    chk("reset.ready", instr_ready, 1);
    chk("reset.freeze", freeze_fetch, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // SM 0001_0010 with a two-cycle stall on the first micro-op
    @(negedge clk); put(1'b1, OPC_SM, 3'd2, 8'h12); #1;
    chk("stall.freeze_acc", freeze_fetch, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instr_valid = 1'b0; stall_in = (i < 2); #1;
      exp_uop($sformatf("stall.hold%0d", i), 1'b1, 1, 0, 1'b0);
      chk("stall.freeze", freeze_fetch, 1);
    end
    @(negedge clk); stall_in = 1'b0; #1;
    exp_uop("stall.second", 1'b1, 4, 1, 1'b1);
    chk("stall.freeze2", freeze_fetch, 1);
    @(negedge clk); #1;
    chk("stall.done", uop_valid, 0);
    chk("stall.freeze_done", freeze_fetch, 0);

    // LM 8'hFF flushed at the third micro-op, then SM 8'h01
    @(negedge clk); put(1'b1, OPC_LM, 3'd4, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instr_valid = 1'b0; flush = (i == 2); #1;
      exp_uop($sformatf("flush.u%0d", i), 1'b1, i, i, 1'b0);
    end
    @(negedge clk); flush = 1'b0; put(1'b1, OPC_SM, 3'd1, 8'h01); #1;
    chk("flush.valid", uop_valid, 0);
    chk("flush.busy", busy, 0);
    chk("flush.ready", instr_ready, 1);
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_uop("flush.sm", 1'b1, 0, 0, 1'b1);
    chk("flush.sm_load", uop_is_load, 0);
    @(negedge clk); #1;
    chk("flush.sm_done", uop_valid, 0);

    // Reset mid-LA, then back-to-back LM 8'h80 / SM 8'h01
    @(negedge clk); put(1'b1, OPC_LA, 3'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); instr_valid = 1'b0; rst_n = (i != 3); #1;
      exp_uop($sformatf("rst.u%0d", i), 1'b1, i, i, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1; put(1'b1, OPC_LM, 3'd2, 8'h80); #1;
    chk("rst.valid", uop_valid, 0);
    chk("rst.k", uop_k, 0);
    chk("rst.offset", uop_offset, 0);
    chk("rst.last", uop_last, 0);
    chk("rst.busy", busy, 0);
    chk("rst.base", uop_base, 0);
    chk("rst.load", uop_is_load, 0);
    chk("rst.ready", instr_ready, 1);
    @(negedge clk); put(1'b1, OPC_SM, 3'd5, 8'h01); #1;
    exp_uop("b2b.lm", 1'b1, 7, 0, 1'b1);
    chk("b2b.ready_busy", instr_ready, 0);
    @(negedge clk); #1;
    chk("b2b.gap", uop_valid, 0);
    chk("b2b.ready_gap", instr_ready, 1);
    @(negedge clk); instr_valid = 1'b0; #1;
    exp_uop("b2b.sm", 1'b1, 0, 0, 1'b1);
    chk("b2b.sm_base", uop_base, 5);
    @(negedge clk); #1;
    chk("b2b.done", uop_valid, 0);

    // Randomized stimulus against the queue model
    m_act = 1'b0; m_q.delete(); m_off = 0; m_base = 3'd0; m_load = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       lasa, multi;
      logic [7:0] eff;
      @(negedge clk);
      rst_n        = (cyc == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      stall_in     = ($urandom_range(0, 3) == 0);
      instr_valid  = 1'($urandom_range(0, 1));
      instr_opcode = ($urandom_range(0, 1) == 1) ? {2'b11, 2'($urandom_range(0, 3))} : 4'($urandom);
      instr_list   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      instr_ra     = 3'($urandom);
      lasa  = (instr_opcode == OPC_LA) || (instr_opcode == OPC_SA);
      multi = lasa || (instr_opcode == OPC_LM) || (instr_opcode == OPC_SM);
      eff   = lasa ? LA_SA_LIST : instr_list;
      #1;
      chk("rnd.ready", instr_ready, !m_act && !stall_in);
      chk("rnd.freeze", freeze_fetch, m_act || (instr_valid && multi && eff != 8'h00 && !flush));
      chk("rnd.busy", busy, m_act);
      chk("rnd.valid", uop_valid, m_act);
      if (m_act) begin
        chk("rnd.k", uop_k, m_q[0]);
        chk("rnd.offset", uop_offset, m_off);
        chk("rnd.last", uop_last, m_q.size() == 1);
        chk("rnd.load", uop_is_load, m_load);
        chk("rnd.base", uop_base, m_base);
      end
      @(posedge clk);
      if (!rst_n) begin
        m_act = 1'b0; m_q.delete(); m_off = 0; m_base = 3'd0; m_load = 1'b0;
      end else if (flush) begin
        m_act = 1'b0; m_q.delete(); m_off = 0;
      end else if (m_act) begin
        if (!stall_in) begin
          void'(m_q.pop_front());
          m_off++;
          if (m_q.size() == 0) m_act = 1'b0;
        end
      end else if (instr_valid && !stall_in && multi && eff != 8'h00) begin
        for (int r = 0; r < 8; r++) if (eff[r]) m_q.push_back(r);
        m_act  = 1'b1;
        m_off  = 0;
        m_base = instr_ra;
        m_load = (instr_opcode == OPC_LM) || (instr_opcode == OPC_LA);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Decode-stage controller that expands multi-register memory instructions (LM, SM, LA, SA) into one single-register micro-op per cycle for the EX/MEM datapath. It walks the 8-bit register list lowest register first and drives the per-transfer register index k, the address offset and the last flag. While sequencing, it asserts freeze_fetch to hold IF/ID. It obeys the hazard unit's freeze by holding its current micro-op.

Parameters:
REG_W, 3, register address width; also the width of k and offset
NREGS, 8, register-list width (must equal 2**REG_W)
OPC_W, 4, opcode width

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
instr_valid  input  1  decode holds a valid instruction
instr_opcode  input  OPC_W  decoded opcode
instr_ra  input  REG_W  base-address register
instr_list  input  NREGS  register list, imm[7:0]; bit i selects Ri
instr_ready  output  1  sequencer can accept the instruction this cycle
stall_in  input  1  hazard-unit freeze; holds the current micro-op
flush  input  1  branch/jump redirect from a later stage; abort
uop_valid  output  1  micro-op present
uop_is_load  output  1  1 for LM/LA, 0 for SM/SA
uop_k  output  REG_W  register transferred by this micro-op
uop_base  output  REG_W  latched base register
uop_offset  output  REG_W  transfer index 0..7; memory address = R[uop_base]+uop_offset
uop_last  output  1  final micro-op of the instruction
freeze_fetch  output  1  hold PC and IF/ID
busy  output  1  state is SEQ

Behaviour:
- Interface: one clock, clk; rst_n is synchronous and active-low.
- Opcodes: LM=4'b1100, SM=4'b1101, LA=4'b1110, SA=4'b1111. LA and SA ignore instr_list and use 8'h7F (R0..R6; R7 is the PC). Any other opcode is not a multi-op.
- Reset (rst_n=0 at an edge): state=IDLE. Pending list, offset, base and op are cleared. uop_valid=0, uop_last=0, uop_k=0, uop_offset=0, busy=0. Reset overrides flush, stall_in and accept.
- States are IDLE and SEQ.
- instr_ready = (state==IDLE) & ~stall_in.
- Non-multi-op with instr_valid: ready stays 1 and the block takes no action.
- IDLE, accept at edge T (instr_valid & instr_ready & multi-op & effective list!=0 & ~flush):
  - latch list, base and op; offset=0; go to SEQ.
  - first micro-op is valid from T+1.
- Multi-op with empty effective list: accepted and treated as a NOP. No micro-op is emitted and the state stays IDLE.
- SEQ outputs: uop_valid=1; uop_k = index of the lowest set bit in the pending list; uop_last = (pending list has exactly one set bit).
- SEQ advance (stall_in=0): clear the bit at uop_k and increment offset. If uop_last, go to IDLE and drive uop_valid=0 in the next cycle.
- SEQ with stall_in=1: state, outputs and offset hold bit-exact.
- Throughput: N set bits give N consecutive micro-ops when unstalled. A new instruction can be accepted no earlier than the cycle after the last micro-op.
- flush=1 in any state: next cycle is IDLE with uop_valid=0 and the pending list cleared. flush beats stall_in and accept. A flush in the same cycle as an accept discards the instruction.
- freeze_fetch = busy | (state==IDLE & instr_valid & multi-op & effective list!=0 & ~flush). It is combinational, so fetch holds in the accept cycle.
- Offset never wraps: at most 8 transfers, final offset is 7.
- uop_k register width matches the k field used by the hazard unit (3 bits). The hazard unit combines uop_k and the load flag into its freeze conditions.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - opcode constants OPC_LM, OPC_SM, OPC_LA, OPC_SA;
  - LA_SA_LIST=8'h7F;
  - REG_W, NREGS.
- One sub-module, prio_enc8: 8-bit lowest-set-bit encoder with outputs idx[2:0], any and onehot_last (popcount==1). It is purely combinational.

Test Plan:
- LM, ra=3, list=8'b1010_0101, no stall: accept at T. Micro-ops on T+1..T+4 have k=0,2,5,7 and offset=0,1,2,3; uop_last only at T+4; is_load=1; busy low at T+5.
- SA, list input 8'hFF: 7 micro-ops, k=0..6, is_load=0, last at k=6. Register 7 is never emitted.
- SM, list=8'b0001_0010, stall_in high for 2 cycles at the first micro-op: k=1 and offset=0 held stable for 3 cycles, then k=4, offset=1, last=1. freeze_fetch stays high throughout.
- LM, list=8'h00: instr_ready=1, no uop_valid, busy stays 0, freeze_fetch=0.
- LM, list=8'hFF, flush at the third micro-op: next cycle uop_valid=0 and IDLE. A following SM, list=8'h01, is accepted and emits k=0, offset=0, last=1.
- rst_n low for one cycle mid-sequence (LA at k=3): all outputs zero next cycle and state IDLE. Then back-to-back LM 8'h80 and SM 8'h01 emit k=7 then k=0 with a one-cycle gap.
